// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Steps an external combinational ALU through its opcodes and streams out each result.
// Optional feature macro: ALU_SEQ_DIVZERO_SKIP_EN (skip opcode 0x3 when the latched opb is zero).
module alu_op_sequencer #(
   parameter int WIDTH   = 8,
   parameter int NUM_OPS = 12,
   parameter int SETTLE  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] opa_in,
   input  logic [WIDTH-1:0] opb_in,
   output logic [WIDTH-1:0] opa,
   output logic [WIDTH-1:0] opb,
   output logic [3:0]       mux,
   input  logic [WIDTH-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [3:0]       res_op,
   output logic             busy,
   output logic             done
);

   localparam int         CW      = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT} state_t;

   state_t           r_state, w_state;
   logic [WIDTH-1:0] r_opa, w_opa;
   logic [WIDTH-1:0] r_opb, w_opb;
   logic [3:0]       r_mux, w_mux;
   logic [CW-1:0]    r_cnt, w_cnt;
   logic [WIDTH-1:0] r_res_data, w_res_data;
   logic [3:0]       r_res_op, w_res_op;
   logic             r_res_valid, w_res_valid;
   logic             r_busy, w_busy;
   logic             r_done, w_done;
   logic             w_skip;
   logic             w_last_op;
   logic [3:0]       w_next_op;

`ifdef ALU_SEQ_DIVZERO_SKIP_EN
   assign w_skip = (r_opb == '0);
`else
   assign w_skip = 1'b0;
`endif

   // With divide skipped, opcode 0x2 may itself be the final opcode of the run.
   assign w_last_op = (r_mux == LAST_OP) ||
                      (w_skip && (r_mux == 4'd2) && (LAST_OP == 4'd3));
   assign w_next_op = (w_skip && (r_mux == 4'd2)) ? 4'd4 : r_mux + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_opa       <= '0;
         r_opb       <= '0;
         r_mux       <= '0;
         r_cnt       <= '0;
         r_res_data  <= '0;
         r_res_op    <= '0;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_opa       <= w_opa;
         r_opb       <= w_opb;
         r_mux       <= w_mux;
         r_cnt       <= w_cnt;
         r_res_data  <= w_res_data;
         r_res_op    <= w_res_op;
         r_res_valid <= w_res_valid;
         r_busy      <= w_busy;
         r_done      <= w_done;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_opa       = r_opa;
      w_opb       = r_opb;
      w_mux       = r_mux;
      w_cnt       = r_cnt;
      w_res_data  = r_res_data;
      w_res_op    = r_res_op;
      w_res_valid = r_res_valid;
      w_busy      = r_busy;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state = S_DRIVE;
               w_opa   = opa_in;
               w_opb   = opb_in;
               w_mux   = 4'd0;
               w_cnt   = '0;
               w_busy  = 1'b1;
            end
         end
         S_DRIVE: begin
            // First opcode gets one extra cycle because the operands land with it.
            if (r_cnt == CW'(SETTLE)) begin
               w_res_data  = alu_result;
               w_res_op    = r_mux;
               w_res_valid = 1'b1;
               w_state     = S_WAIT;
            end else begin
               w_cnt = r_cnt + CW'(1);
            end
         end
         S_WAIT: begin
            if (res_ready) begin
               w_res_valid = 1'b0;
               if (w_last_op) begin
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
                  w_state = S_IDLE;
               end else begin
                  w_mux   = w_next_op;
                  w_cnt   = CW'(1);
                  w_state = S_DRIVE;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign opa       = r_opa;
   assign opb       = r_opb;
   assign mux       = r_mux;
   assign res_data  = r_res_data;
   assign res_op    = r_res_op;
   assign res_valid = r_res_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - Directed vector bench for alu_op_sequencer with a behavioural ALU.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start, start3;
   logic [7:0] opa_in, opb_in;
   logic [7:0] opa, opb, res_data, alu_result;
   logic [3:0] mux, res_op;
   logic       res_valid, res_ready, busy, done;
   logic [7:0] opa3, opb3, res_data3, alu_result3;
   logic [3:0] mux3, res_op3;
   logic       res_valid3, res_ready3, busy3, done3;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a * b;
         4'h3: return (b == 8'h00) ? 8'hFF : a / b;
         4'h4: return ~a;
         4'h5: return a & b;
         4'h6: return a | b;
         4'h7: return ~(a & b);
         4'h8: return ~(a | b);
         4'h9: return a ^ b;
         4'hA: return a << 1;
         4'hB: return a >> 1;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result  = alu_model(opa, opb, mux);
   assign alu_result3 = alu_model(opa3, opb3, mux3);

   alu_op_sequencer #(.WIDTH(8), .NUM_OPS(12), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opa_in(opa_in), .opb_in(opb_in),
      .opa(opa), .opb(opb), .mux(mux), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
      .busy(busy), .done(done)
   );

   alu_op_sequencer #(.WIDTH(8), .NUM_OPS(12), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .opa_in(opa_in), .opb_in(opb_in),
      .opa(opa3), .opb(opb3), .mux(mux3), .alu_result(alu_result3),
      .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3), .res_op(res_op3),
      .busy(busy3), .done(done3)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] data;
   } vec_t;

   vec_t t2[12];
   vec_t t6[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input bit sel, output logic [7:0] d, output logic [3:0] op, output int at);
      bit got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (sel ? res_valid3 : res_valid) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL res_valid_timeout: got 0 expected 1 within 40 cycles");
      end
      d  = sel ? res_data3 : res_data;
      op = sel ? res_op3 : res_op;
      at = cyc;
   endtask

   task automatic do_start(input bit sel, input logic [7:0] a, input logic [7:0] b, output int s);
      @(negedge clk);
      opa_in = a;
      opb_in = b;
      if (sel) start3 = 1'b1;
      else     start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start3 = 1'b0;
      s = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [7:0] d;
      logic [3:0] op;
      int         at, prev, s;

      t2[0]  = {4'h0, 8'hA5}; t2[1]  = {4'h1, 8'h2F}; t2[2]  = {4'h2, 8'h6E};
      t2[3]  = {4'h3, 8'h01}; t2[4]  = {4'h4, 8'h95}; t2[5]  = {4'h5, 8'h2A};
      t2[6]  = {4'h6, 8'h7B}; t2[7]  = {4'h7, 8'hD5}; t2[8]  = {4'h8, 8'h84};
      t2[9]  = {4'h9, 8'h51}; t2[10] = {4'hA, 8'hD4}; t2[11] = {4'hB, 8'h35};
      t6[0]  = {4'h0, 8'h6A}; t6[1]  = {4'h1, 8'h6A}; t6[2]  = {4'h2, 8'h00};
      t6[3]  = {4'h3, 8'hFF}; t6[4]  = {4'h4, 8'h95}; t6[5]  = {4'h5, 8'h00};
      t6[6]  = {4'h6, 8'h6A}; t6[7]  = {4'h7, 8'hFF}; t6[8]  = {4'h8, 8'h95};
      t6[9]  = {4'h9, 8'h6A}; t6[10] = {4'hA, 8'hD4}; t6[11] = {4'hB, 8'h35};

      rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
      opa_in = 8'h00; opb_in = 8'h00; res_ready = 1'b1; res_ready3 = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", {opa, opb, mux, res_data, res_op, res_valid, busy, done}, 64'h0);
      check("reset_outputs_s3", {opa3, opb3, mux3, res_data3, res_op3, res_valid3, busy3, done3}, 64'h0);
      rst_n = 1'b1;

      // T1: abandon a run by reset after its third result
      do_start(1'b0, 8'h6A, 8'h3B, s);
      for (int i = 0; i < 3; i++) begin
         wait_valid(1'b0, d, op, at);
         check("t1_result", {op, d}, {t2[i].op, t2[i].data});
      end
      rst_n = 1'b0;
      #1;
      check("t1_async_reset", {opa, opb, mux, res_data, res_op, res_valid, busy, done}, 64'h0);
      @(negedge clk);
      check("t1_reset_held", {opa, opb, mux, res_data, res_op, res_valid, busy, done}, 64'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t1_no_done", {busy, done}, 2'b00);
      check("t1_done_count", done_cnt, 0);

      // T2 full run, with T3 backpressure on op 4 and T4 start-while-busy on op 7
      do_start(1'b0, 8'h6A, 8'h3B, s);
      prev = s;
      for (int i = 0; i < 12; i++) begin
         wait_valid(1'b0, d, op, at);
         check("t2_result", {op, d}, {t2[i].op, t2[i].data});
         if (i == 0)      check("t2_latency", at - s, 2);
         else if (i != 5) check("t2_spacing", at - prev, 2);
         prev = at;
         if (i == 3) begin
            @(negedge clk);
            res_ready = 1'b0;
         end
         if (i == 4) begin
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("t3_hold", {res_valid, res_data, res_op, mux}, {1'b1, 8'h95, 4'h4, 4'h4});
            end
            res_ready = 1'b1;
         end
         if (i == 7) begin
            start = 1'b1; opa_in = 8'hFF; opb_in = 8'h00;
            @(negedge clk);
            start = 1'b0;
            check("t4_operands_kept", {opa, opb, busy}, {8'h6A, 8'h3B, 1'b1});
         end
      end
      @(negedge clk);
      check("t2_done_pulse", {done, busy, res_valid}, 3'b100);
      @(negedge clk);
      check("t2_done_clear", {done, busy}, 2'b00);
      check("t2_done_count", done_cnt, 1);

      // T5: SETTLE=3 latency and spacing
      do_start(1'b1, 8'h6A, 8'h3B, s);
      prev = s;
      for (int i = 0; i < 3; i++) begin
         wait_valid(1'b1, d, op, at);
         check("t5_result", {op, d}, {t2[i].op, t2[i].data});
         if (i == 0) check("t5_latency", at - s, 4);
         else        check("t5_spacing", at - prev, 4);
         prev = at;
      end

      // T6: divide by zero operand
      do_start(1'b0, 8'h6A, 8'h00, s);
      for (int j = 0; j < 12; j++) begin
`ifdef ALU_SEQ_DIVZERO_SKIP_EN
         if (j == 3) continue;
`endif
         wait_valid(1'b0, d, op, at);
         check("t6_result", {op, d}, {t6[j].op, t6[j].data});
      end
      @(negedge clk);
      check("t6_done_pulse", {done, res_valid}, 2'b10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t6_no_extra", {res_valid, busy}, 2'b00);
      end
      check("t6_done_count", done_cnt, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
